cpu_control_unit: RTL
=====================

Name: cpu_control_unit

Overview:
Multi-cycle sequencer for the 13-bit CPU datapath. Owns the program counter and drives memory read/write/instruction-select, operand-type mux select, ALU opcode, ALU start strobe and register write enable. Steps each instruction through FETCH, DECODE, EXECUTE, MEM, WRITEBACK and PC update. Handshakes with main memory via memDone, with a timeout watchdog.

Parameters:
PC_W, 13, program counter / address width
RESET_PC, 0, PC value loaded on reset
MEM_TIMEOUT, 15, max cycles to wait for memDone before faulting (1..255)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
run  in  1  level; 1 = allowed to leave IDLE and fetch
memDone  in  1  memory access complete, one-cycle pulse
Opcode  in  3  decoded opcode of current instruction
BEQ  in  1  branch-equal compare result, valid in EXECUTE and later
newPC  in  PC_W  branch target from datapath
PC  out  PC_W  current program counter
read  out  1  memory read request
write  out  1  memory write request
instruction  out  1  1 = memory address from PC (fetch), 0 = from ALU result
instructionType  out  1  0 = sign-extended immediate to ALU, 1 = register
ALU_Op  out  3  ALU operation
ALUSTART  out  1  one-cycle ALU start strobe
regWrite  out  1  register file write enable, one cycle
halted  out  1  HALT executed, sticky
fault  out  1  memory timeout, sticky

Behaviour:
- Reset (reset=0, async): state=IDLE, PC=RESET_PC, all other outputs 0, watchdog=0. Reset mid-access abandons the access with no register write.
- Opcode map: 000 ADD, 001 SUB, 010 AND, 011 OR (R-type, instructionType=1); 100 ADDI (instructionType=0); 101 LW, 110 SW (instructionType=0, ALU_Op=000 for address); 111 BEQ (instructionType=1, ALU_Op=001). Encoding 111 with newPC==PC is HALT.
- ALU_Op = Opcode for 000-011, 000 for 100-110, 001 for 111.
- IDLE: outputs 0; run=1 -> FETCH next cycle.
- FETCH: read=1, instruction=1 held until memDone; memDone -> DECODE. Watchdog counts cycles in FETCH; reaching MEM_TIMEOUT without memDone -> FAULT.
- DECODE: one cycle, instruction=1 held so the decoder keeps the fetched word; ALU_Op/instructionType set from Opcode -> EXECUTE.
- EXECUTE: ALUSTART=1 for exactly this cycle -> MEM for LW/SW, WB for ALU/ADDI, PCUPD for BEQ.
- MEM: instruction=0; LW read=1, SW write=1, held until memDone (watchdog as FETCH) -> WB for LW, PCUPD for SW.
- WB: regWrite=1 for one cycle -> PCUPD.
- PCUPD: BEQ op with BEQ=1: if newPC==PC -> HALT state, halted=1, PC unchanged; else PC=newPC. Otherwise PC=PC+1 modulo 2^PC_W (wraps max to 0). Then FETCH if run=1, else IDLE.
- HALT, FAULT: terminal until reset; all strobes 0; halted/fault stay 1.
- Watchdog clears on every state entry; memDone in the same cycle the count reaches MEM_TIMEOUT is success.
- memDone outside FETCH/MEM is ignored.
- run deasserted mid-instruction: the instruction completes; stop at PCUPD.
- read and write never both 1; ALUSTART and regWrite never in the same cycle.
- Cycles per instruction with single-cycle memDone: ALU/ADDI 5, LW 6, SW 5, BEQ 4.

Test Plan:
- Reset with run=1, memDone pulsed 1 cycle after each request, Opcode=000 -> PC 0->1; ALUSTART in cycle 3, regWrite in cycle 4, 5 cycles total.
- LW (101) at PC=4 -> read/instruction=1 in FETCH, then read=1/instruction=0 in MEM, instructionType=0, regWrite after second memDone, PC=5.
- SW (110) -> write=1 in MEM only, no regWrite, PC increments; confirm read=0 throughout MEM.
- BEQ (111) with BEQ=1, newPC=0x0A0, PC=0x010 -> PC=0x0A0; with BEQ=0 -> PC=0x011; with newPC==PC -> halted=1, no further reads.
- PC=0x1FFF, ADD -> PC wraps to 0x0000.
- memDone withheld in FETCH -> fault=1 after 15 cycles, all strobes 0; assert reset=0 mid-MEM of a LW -> outputs 0 immediately, no regWrite, PC=RESET_PC.

Source files
------------

// File: rtl/cpu_control_unit_if.sv
// Control bus between the instruction sequencer and the datapath/memory side.
// master = sequencer, slave = datapath + memory.
interface cpu_control_unit_if #(
  parameter int PC_W = 13
);
  logic            run;
  logic            memDone;
  logic [2:0]      Opcode;
  logic            BEQ;
  logic [PC_W-1:0] newPC;
  logic [PC_W-1:0] PC;
  logic            read;
  logic            write;
  logic            instruction;
  logic            instructionType;
  logic [2:0]      ALU_Op;
  logic            ALUSTART;
  logic            regWrite;
  logic            halted;
  logic            fault;

  modport master (
    input  run, memDone, Opcode, BEQ, newPC,
    output PC, read, write, instruction, instructionType, ALU_Op,
           ALUSTART, regWrite, halted, fault
  );

  modport slave (
    output run, memDone, Opcode, BEQ, newPC,
    input  PC, read, write, instruction, instructionType, ALU_Op,
           ALUSTART, regWrite, halted, fault
  );
endinterface

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer for the 13-bit CPU: owns the PC and steps each
// instruction through fetch, decode, execute, memory, writeback, PC update.
//
// state   | meaning
// IDLE    | parked, waiting for run
// FETCH   | instruction read from PC, waiting for memDone
// DECODE  | decoder sees fetched word, ALU controls captured
// EXECUTE | one-cycle ALU start strobe
// MEM     | LW read / SW write at ALU address, waiting for memDone
// WB      | one-cycle register file write
// PCUPD   | PC <= PC+1 or branch target; self-branch halts
// HALT    | terminal until reset, halted=1
// FAULT   | terminal until reset, memory timeout, fault=1
module cpu_control_unit #(
  parameter int              PC_W        = 13,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  cpu_control_unit_if.master bus
);
  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_FETCH   = 4'd1;
  localparam logic [3:0] S_DECODE  = 4'd2;
  localparam logic [3:0] S_EXECUTE = 4'd3;
  localparam logic [3:0] S_MEM     = 4'd4;
  localparam logic [3:0] S_WB      = 4'd5;
  localparam logic [3:0] S_PCUPD   = 4'd6;
  localparam logic [3:0] S_HALT    = 4'd7;
  localparam logic [3:0] S_FAULT   = 4'd8;

  localparam logic [2:0] OP_LW  = 3'b101;
  localparam logic [2:0] OP_SW  = 3'b110;
  localparam logic [2:0] OP_BEQ = 3'b111;

  // Watchdog holds (cycles spent in the wait state - 1); the last allowed
  // cycle is the one where it equals MEM_TIMEOUT-1.
  localparam logic [7:0]      WDOG_LAST = 8'(MEM_TIMEOUT - 1);
  localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};

  logic [3:0]      r_state;
  logic [3:0]      w_next;
  logic [PC_W-1:0] r_pc;
  logic [2:0]      r_op;
  logic [2:0]      r_alu_op;
  logic            r_itype;
  logic [7:0]      r_wdog;
  logic [2:0]      w_dec_alu;
  logic            w_dec_itype;
  logic            w_wdog_last;
  logic            w_branch_taken;
  logic            w_self_branch;

  assign w_wdog_last    = (r_wdog == WDOG_LAST);
  assign w_branch_taken = (r_op == OP_BEQ) && bus.BEQ;
  assign w_self_branch  = w_branch_taken && (bus.newPC == r_pc);

  // Opcode to ALU operation and operand-type select
  always_comb begin
    w_dec_alu   = 3'b000;
    w_dec_itype = 1'b0;
    if (!bus.Opcode[2]) begin
      w_dec_alu   = bus.Opcode;
      w_dec_itype = 1'b1;
    end else if (bus.Opcode == OP_BEQ) begin
      w_dec_alu   = 3'b001;
      w_dec_itype = 1'b1;
    end
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (bus.run) w_next = S_FETCH;
      S_FETCH: begin
        if (bus.memDone)      w_next = S_DECODE;
        else if (w_wdog_last) w_next = S_FAULT;
      end
      S_DECODE:  w_next = S_EXECUTE;
      S_EXECUTE: begin
        if (r_op == OP_LW || r_op == OP_SW) w_next = S_MEM;
        else if (r_op == OP_BEQ)            w_next = S_PCUPD;
        else                                w_next = S_WB;
      end
      S_MEM: begin
        if (bus.memDone)      w_next = (r_op == OP_LW) ? S_WB : S_PCUPD;
        else if (w_wdog_last) w_next = S_FAULT;
      end
      S_WB:      w_next = S_PCUPD;
      S_PCUPD: begin
        if (w_self_branch) w_next = S_HALT;
        else if (bus.run)  w_next = S_FETCH;
        else               w_next = S_IDLE;
      end
      S_HALT:    w_next = S_HALT;
      S_FAULT:   w_next = S_FAULT;
      default:   w_next = S_IDLE;
    endcase
  end

  // State, latched decode and watchdog; watchdog restarts on every state change
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= 3'b000;
      r_alu_op <= 3'b000;
      r_itype  <= 1'b0;
      r_wdog   <= 8'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op     <= bus.Opcode;
        r_alu_op <= w_dec_alu;
        r_itype  <= w_dec_itype;
      end
      if ((w_next == r_state) && (r_state == S_FETCH || r_state == S_MEM))
        r_wdog <= r_wdog + 8'd1;
      else
        r_wdog <= 8'd0;
    end
  end

  // Program counter: sequential increment (wrapping) or taken branch target
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else if (r_state == S_PCUPD && !w_self_branch) begin
      r_pc <= w_branch_taken ? bus.newPC : r_pc + PC_ONE;
    end
  end

  // Moore outputs decoded from state; DECODE drives live decode, later states the latched copy
  always_comb begin
    bus.read            = 1'b0;
    bus.write           = 1'b0;
    bus.instruction     = 1'b0;
    bus.instructionType = 1'b0;
    bus.ALU_Op          = 3'b000;
    bus.ALUSTART        = 1'b0;
    bus.regWrite        = 1'b0;
    case (r_state)
      S_FETCH: begin
        bus.read        = 1'b1;
        bus.instruction = 1'b1;
      end
      S_DECODE: begin
        bus.instruction     = 1'b1;
        bus.ALU_Op          = w_dec_alu;
        bus.instructionType = w_dec_itype;
      end
      S_EXECUTE: begin
        bus.ALUSTART        = 1'b1;
        bus.ALU_Op          = r_alu_op;
        bus.instructionType = r_itype;
      end
      S_MEM: begin
        bus.read            = (r_op == OP_LW);
        bus.write           = (r_op == OP_SW);
        bus.ALU_Op          = r_alu_op;
        bus.instructionType = r_itype;
      end
      S_WB: begin
        bus.regWrite        = 1'b1;
        bus.ALU_Op          = r_alu_op;
        bus.instructionType = r_itype;
      end
      S_PCUPD: begin
        bus.ALU_Op          = r_alu_op;
        bus.instructionType = r_itype;
      end
      default: ;
    endcase
  end

  assign bus.PC     = r_pc;
  assign bus.halted = (r_state == S_HALT);
  assign bus.fault  = (r_state == S_FAULT);
endmodule
